mul_lfsr_rx: RTL and testbench

Receive-side counterpart of the multiple-LFSR chip generator: recovers chip timing from a looped-back or sliced ADC bit stream, self-synchronises a local LFSR of the selected order, and reports lock, sequence-start, period count and bit errors. It sits in the RedPitaya ADC path of the FDI-ANT design and closes the loop for BER and alignment checks of the DAC test-sequence generator.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/chip_sampler.sv | 33 +++
 rtl/mul_lfsr_rx.sv | 158 +++++++++++++++
 tb/tb_mul_lfsr_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: tap masks, degree helpers and receiver FSM states shared by the LFSR generator and receiver
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, TRACK, LOCKED} state_t;

    // Fibonacci tap masks (bit k-1 set for each x^k term except x^0), indexed by order select
    localparam logic [11:0] TAPS [8] = '{
        12'h014, 12'h030, 12'h060, 12'h0B8,
        12'h110, 12'h240, 12'h500, 12'hE08
    };

    function automatic logic [3:0] degree(input logic [2:0] sel);
        return 4'(sel) + 4'd5;
    endfunction

    function automatic logic [11:0] deg_mask(input logic [2:0] sel);
        return 12'hFFF >> (4'd7 - 4'(sel));
    endfunction

endpackage

// File: rtl/chip_sampler.sv
// chip_sampler: recovers chip timing from stream transitions and emits a sample strobe per chip
module chip_sampler (
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    input  logic [7:0] sel_div_i,
    input  logic       sig_i,
    output logic       stb,
    output logic       smp
);

    logic       sig_q, sig_d, tog;
    logic [7:0] p, n;

    assign n   = (sel_div_i < 8'd2) ? 8'd1 : sel_div_i;
    assign tog = sig_q ^ sig_d;
    assign smp = sig_q;
    assign stb = (n == 8'd1) || (!tog && p == (n >> 1));

    // input register, edge history and phase counter that restarts on every transition
    always_ff @(posedge clk) begin
        if (srst) begin
            sig_q <= 1'b0;
            sig_d <= 1'b0;
            p     <= 8'd0;
        end else if (en) begin
            sig_q <= sig_i;
            sig_d <= sig_q;
            p     <= (tog || p >= n - 8'd1) ? 8'd0 : p + 8'd1;
        end
    end

endmodule

// File: rtl/mul_lfsr_rx.sv
// mul_lfsr_rx: self-synchronising LFSR receiver reporting lock, sequence start, period count and bit errors
module mul_lfsr_rx
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic [7:0]       sel_div_i,
    input  logic [7:0]       order_i,
    input  logic [2:0]       rep_i,
    input  logic             sig_i,
    output logic             lock_o,
    output logic             flag_o,
    output logic             done_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    state_t           state, state_n;
    logic [11:0]      r, r_n, r_ld, r_adv, dmask;
    logic [3:0]       lcnt, lcnt_n, pcnt, pcnt_n, deg, rep_n;
    logic [MW-1:0]    mcnt, mcnt_n;
    logic [LW-1:0]    miss, miss_n;
    logic [ERR_W-1:0] err, err_n;
    logic [2:0]       ord_q;
    logic             pend, pend_n, chg, stb, smp, pred, hit;
    logic             flag_q, flag_n, done_q, done_n;
    logic             unused_ord;

    chip_sampler u_smp (
        .clk       (clk),
        .srst      (srst),
        .en        (en),
        .sel_div_i (sel_div_i),
        .sig_i     (sig_i),
        .stb       (stb),
        .smp       (smp)
    );

    assign unused_ord = ^order_i[7:3];
    assign deg        = degree(order_i[2:0]);
    assign dmask      = deg_mask(order_i[2:0]);
    assign pred       = ^(r & TAPS[order_i[2:0]]);
    assign hit        = smp == pred;
    assign r_adv      = {r[10:0], pred} & dmask;
    assign r_ld       = {r[10:0], smp} & dmask;
    assign rep_n      = (rep_i == 3'd0) ? 4'd8 : {1'b0, rep_i};
    assign chg        = pend || (state != IDLE && ord_q != order_i[2:0]);
    assign lock_o     = state == LOCKED;
    assign flag_o     = flag_q & en;
    assign done_o     = done_q & en;
    assign err_cnt_o  = err;

    // next state: everything advances only on enabled strobes; an order change forces a reload
    always_comb begin
        state_n = state;
        r_n     = r;
        lcnt_n  = lcnt;
        mcnt_n  = mcnt;
        miss_n  = miss;
        pcnt_n  = pcnt;
        err_n   = err;
        pend_n  = en ? chg : pend;
        flag_n  = 1'b0;
        done_n  = 1'b0;
        if (en && stb) begin
            pend_n = 1'b0;
            if (chg) begin
                state_n = LOAD;
                r_n     = '0;
                lcnt_n  = '0;
                mcnt_n  = '0;
                miss_n  = '0;
                pcnt_n  = '0;
            end else begin
                case (state)
                    IDLE: begin
                        state_n = LOAD;
                        lcnt_n  = '0;
                    end
                    LOAD: begin
                        r_n    = r_ld;
                        lcnt_n = lcnt + 4'd1;
                        if (lcnt + 4'd1 == deg) begin
                            lcnt_n  = '0;
                            state_n = (r_ld != '0) ? TRACK : LOAD;
                            mcnt_n  = '0;
                        end
                    end
                    TRACK: begin
                        if (hit) begin
                            r_n    = r_adv;
                            mcnt_n = mcnt + 1'b1;
                            if (mcnt + 1'b1 == MW'(LOCK_CNT)) begin
                                state_n = LOCKED;
                                miss_n  = '0;
                                pcnt_n  = '0;
                            end
                        end else begin
                            state_n = LOAD;
                            lcnt_n  = '0;
                        end
                    end
                    default: begin
                        r_n    = r_adv;
                        miss_n = hit ? '0 : miss + 1'b1;
                        err_n  = (!hit && err != '1) ? err + 1'b1 : err;
                        if (!hit && miss + 1'b1 == LW'(LOSS_CNT)) begin
                            state_n = LOAD;
                            lcnt_n  = '0;
                        end
                        if (r_adv == dmask) begin
                            flag_n = 1'b1;
                            done_n = pcnt + 4'd1 == rep_n;
                            pcnt_n = (pcnt + 4'd1 == rep_n) ? 4'd0 : pcnt + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    // state register; synchronous reset overrides enable and every other event
    always_ff @(posedge clk) begin
        if (srst) begin
            state  <= IDLE;
            r      <= '0;
            lcnt   <= '0;
            mcnt   <= '0;
            miss   <= '0;
            pcnt   <= '0;
            err    <= '0;
            pend   <= 1'b0;
            ord_q  <= '0;
            flag_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            r      <= r_n;
            lcnt   <= lcnt_n;
            mcnt   <= mcnt_n;
            miss   <= miss_n;
            pcnt   <= pcnt_n;
            err    <= err_n;
            pend   <= pend_n;
            flag_q <= flag_n;
            done_q <= done_n;
            if (en) ord_q <= order_i[2:0];
        end
    end

endmodule

// File: tb/tb_mul_lfsr_rx.sv
// tb_mul_lfsr_rx: directed loopback checks of lock, flag/done periods, error counting and reload behaviour
module tb_mul_lfsr_rx;

    logic        clk = 1'b0, srst = 1'b1, en = 1'b1, sig_i = 1'b0;
    logic [7:0]  sel_div_i = 8'd4, order_i = 8'd0;
    logic [2:0]  rep_i = 3'd3;
    logic        lock_o, flag_o, done_o;
    logic [15:0] err_cnt_o;

    int n_cmp = 0, n_bad = 0;
    int cyc, lock_cyc, last_flag, flag_gap, nflag, last_done, done_gap, ndone, lone_done;
    int ndiv = 4, gdeg = 5;
    logic [11:0] g = 12'd1, gtap = 12'h014, gmask = 12'h01F;

    always #5 clk = ~clk;

    mul_lfsr_rx dut (
        .clk       (clk),
        .srst      (srst),
        .en        (en),
        .sel_div_i (sel_div_i),
        .order_i   (order_i),
        .rep_i     (rep_i),
        .sig_i     (sig_i),
        .lock_o    (lock_o),
        .flag_o    (flag_o),
        .done_o    (done_o),
        .err_cnt_o (err_cnt_o)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        lock_cyc  = -1;
        last_flag = -1;
        flag_gap  = -1;
        nflag     = 0;
        last_done = -1;
        done_gap  = -1;
        ndone     = 0;
        lone_done = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (lock_o === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
        if (flag_o === 1'b1) begin
            if (last_flag >= 0) flag_gap = cyc - last_flag;
            last_flag = cyc;
            nflag++;
        end
        if (done_o === 1'b1) begin
            if (last_done >= 0) done_gap = cyc - last_done;
            last_done = cyc;
            ndone++;
            if (flag_o !== 1'b1) lone_done++;
        end
    endtask

    task automatic gen_set(input int d, input logic [11:0] t);
        gdeg  = d;
        gtap  = t;
        gmask = 12'hFFF >> (12 - d);
        g     = 12'd1;
    endtask

    // mode 0: generator chip, 1: inverted chip, 2: stuck at zero
    task automatic chip(input int mode);
        g     = {g[10:0], ^(g & gtap)} & gmask;
        sig_i = (mode == 2) ? 1'b0 : (g[0] ^ (mode == 1));
        repeat (ndiv) tick();
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) chip(mode);
    endtask

    task automatic wait_lock(input int budget);
        for (int i = 0; i < budget && lock_o !== 1'b1; i++) chip(0);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        repeat (2) tick();
        srst = 1'b0;
        clr_mon();
        cyc = 0;
    endtask

    initial begin
        cyc = 0;
        clr_mon();
        gen_set(5, 12'h014);
        do_reset();
        chk("rst_lock", lock_o, 0);
        chk("rst_flag", flag_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_cnt_o, 0);

        wait_lock(60);
        chk("a_lock", lock_o, 1);
        chk("a_lock_time_80_100", (lock_cyc >= 80 && lock_cyc <= 100), 1);
        run(400, 0);
        chk("a_flag_gap", flag_gap, 124);
        chk("a_done_gap", done_gap, 372);
        chk("a_nflag_12_13", (nflag >= 12 && nflag <= 13), 1);
        chk("a_done_with_flag", lone_done, 0);
        chk("a_err0", err_cnt_o, 0);

        chip(1);
        run(10, 0);
        chk("a_err1", err_cnt_o, 1);
        chk("a_lock_after_1miss", lock_o, 1);
        run(3, 1);
        run(10, 0);
        chk("a_err4", err_cnt_o, 4);
        chk("a_lock_after_3miss", lock_o, 1);

        srst = 1'b1;
        tick();
        chk("srst_lock", lock_o, 0);
        chk("srst_err", err_cnt_o, 0);
        chk("srst_flag", flag_o, 0);
        chk("srst_done", done_o, 0);
        srst = 1'b0;
        clr_mon();
        wait_lock(60);
        chk("srst_relock", lock_o, 1);

        run(4, 1);
        run(3, 2);
        chk("loss_lock", lock_o, 0);
        chk("loss_err", err_cnt_o, 4);
        run(150, 2);
        chk("zero_stays_unlocked", lock_o, 0);
        chk("zero_err_kept", err_cnt_o, 4);

        sel_div_i = 8'd0;
        ndiv = 1;
        gen_set(5, 12'h014);
        do_reset();
        wait_lock(40);
        chk("d0_lock", lock_o, 1);
        chk("d0_lock_cyc", lock_cyc, 22);
        run(200, 0);
        chk("d0_flag_gap", flag_gap, 31);
        chk("d0_done_gap", done_gap, 93);

        sel_div_i = 8'd1;
        gen_set(5, 12'h014);
        do_reset();
        wait_lock(40);
        chk("d1_lock", lock_o, 1);
        chk("d1_lock_cyc", lock_cyc, 22);
        run(200, 0);
        chk("d1_flag_gap", flag_gap, 31);

        clr_mon();
        en = 1'b0;
        repeat (100) tick();
        chk("en_no_flag", nflag, 0);
        chk("en_lock_held", lock_o, 1);
        en = 1'b1;
        run(100, 0);
        chk("en_resume_err", err_cnt_o, 0);
        chk("en_resume_flag_gap", flag_gap, 31);

        chip(1);
        run(5, 0);
        chk("d1_err1", err_cnt_o, 1);

        order_i = 8'd7;
        gen_set(12, 12'hE08);
        run(3, 0);
        chk("ord_unlock", lock_o, 0);
        clr_mon();
        wait_lock(200);
        chk("ord_relock", lock_o, 1);
        chk("ord_err_kept", err_cnt_o, 1);
        run(8300, 0);
        chk("ord_flag_gap", flag_gap, 4095);
        chk("ord_err_final", err_cnt_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
